// File: rtl/chroma_key_frame_ctrl_if.sv
// Pixel stream bundle for the chroma-key frame controller.
// Carries the fg/bg pair input (valid/ready) and the composited output
// (valid/ready with sof/eof). slave = compositor, master = stream side.
interface chroma_key_frame_ctrl_if;
  logic [23:0] fg_data;
  logic        fg_valid;
  logic [23:0] bg_data;
  logic        bg_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eof;

  modport slave (
    input  fg_data, fg_valid, bg_data, bg_valid, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eof
  );

  modport master (
    output fg_data, fg_valid, bg_data, bg_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/chroma_key_frame_ctrl.sv
// Chroma-key frame sequencer: streams one frame of fg/bg pairs through a
// one-stage compare/select stage and posts a status word at end of frame.
// Ports: clock, reset (async, active high); ctrl_reg/key_reg/thr_reg from
// the register bank; px = pixel stream interface (slave side);
// stat_data/stat_we = status write port; busy = frame in progress.
// Optional: define CK_WATCHDOG_EN for the idle-cycle watchdog.
module chroma_key_frame_ctrl #(
  parameter int FRAME_PIXELS   = 76800,
  parameter int CNT_W          = 17,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             ctrl_reg,
  input  logic [31:0]             key_reg,
  input  logic [31:0]             thr_reg,
  chroma_key_frame_ctrl_if.slave  px,
  output logic [31:0]             stat_data,
  output logic                    stat_we,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, nxt;
  logic             start_q;
  logic [23:0]      key_q;
  logic [7:0]       thr_q;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic             abort_flag;
  logic [23:0]      out_data;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;

  logic        start_ev;
  logic        abort;
  logic        in_ready;
  logic        accept;
  logic        fire;
  logic        last;
  logic        match;
  logic        timeout;
  logic [31:0] mc32;
  logic [31:0] stat_nxt;

  function automatic logic [8:0] absdiff(input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[8] ? -d : d;
  endfunction

  assign start_ev = ctrl_reg[0] && !start_q;
  assign abort    = ctrl_reg[1];
  // Abort wins over acceptance: the pair is refused in the abort cycle.
  assign in_ready = (state == RUN) && !abort
                 && (!out_valid || px.out_ready);
  assign accept   = in_ready && px.fg_valid && px.bg_valid;
  assign fire     = out_valid && px.out_ready;
  assign last     = pix_cnt == CNT_W'(FRAME_PIXELS - 1);

  assign match =
    (absdiff(px.fg_data[23:16], key_q[23:16]) <= {1'b0, thr_q}) &&
    (absdiff(px.fg_data[15:8],  key_q[15:8])  <= {1'b0, thr_q}) &&
    (absdiff(px.fg_data[7:0],   key_q[7:0])   <= {1'b0, thr_q});

  assign mc32 = 32'(match_cnt);

`ifdef CK_WATCHDOG_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IW-1:0] idle_cnt;
  logic          active;

  assign active  = (state == RUN) || (state == DRAIN);
  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
  assign timeout = active && !accept && !fire
                && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!active || accept || fire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign stat_nxt = {1'b1, abort_flag | timeout, timeout, mc32[28:0]};

  logic unused_bits;
  assign unused_bits = ^{ctrl_reg[31:2], key_reg[31:24],
                         thr_reg[31:8], mc32[31:29]};
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;

  assign timeout  = 1'b0;
  assign stat_nxt = {1'b1, abort_flag, mc32[29:0]};

  logic unused_bits;
  assign unused_bits = ^{ctrl_reg[31:2], key_reg[31:24],
                         thr_reg[31:8], mc32[31:30]};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ev) nxt = RUN;
      end
      RUN: begin
        if (timeout) nxt = DONE;
        else if (abort || (accept && last)) nxt = DRAIN;
      end
      DRAIN: begin
        if (timeout || !out_valid || px.out_ready) nxt = DONE;
      end
      DONE: begin
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q    <= 1'b0;
      key_q      <= '0;
      thr_q      <= '0;
      pix_cnt    <= '0;
      match_cnt  <= '0;
      abort_flag <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      stat_data  <= '0;
    end else begin
      start_q <= ctrl_reg[0];
      if (state == IDLE && start_ev) begin
        pix_cnt    <= '0;
        match_cnt  <= '0;
        abort_flag <= 1'b0;
        key_q      <= key_reg[23:0];
        thr_q      <= thr_reg[7:0];
      end
      if (state == RUN && abort) abort_flag <= 1'b1;
      if (accept) begin
        pix_cnt   <= pix_cnt + 1'b1;
        if (match) match_cnt <= match_cnt + 1'b1;
        out_data  <= match ? px.bg_data : px.fg_data;
        out_valid <= 1'b1;
        out_sof   <= pix_cnt == '0;
        out_eof   <= last;
      end else if (fire || timeout) begin
        // Timeout drops a held pixel; out_data itself is left as is.
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
      end
      if (nxt == DONE && state != DONE) stat_data <= stat_nxt;
    end
  end

  assign px.in_ready  = in_ready;
  assign px.out_data  = out_data;
  assign px.out_valid = out_valid;
  assign px.out_sof   = out_sof;
  assign px.out_eof   = out_eof;
  assign stat_we      = state == DONE;
  assign busy         = state != IDLE;

endmodule
